// File: rtl/seven_seg_scan_driver.sv
// Multi-digit seven-segment scan driver: shadow-registered BCD digits multiplexed onto one segment bus.
// Latency: registered outputs; a load or blank_lz change is visible on seg one edge after it is sampled.
// Backpressure: none; the display scan is free-running and load is accepted on any non-reset edge.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Pin-level idle values: everything dark in whichever polarity the board uses.
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic [NUM_DIGITS-1:0]   zero_from;   // zero_from[i]: digits i..top are all zero
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              seg_ah;
  logic [NUM_DIGITS-1:0]   an_ah;

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_start_q;

  // BCD to segments (a = bit 0 .. g = bit 6); codes above 9 show a lone dash.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Shadow register: a held copy of the digits so the scan never shows a half-updated value.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= bcd_in;
    end
  end

  // Refresh counter and digit index: the index steps once per REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Walk down from the top digit to find the run of leading zeros (invalid codes break the run).
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run & (shadow[4*i +: 4] == 4'd0);
      zero_from[i] = run;
    end
  end

  // Select the digit under the scan and decide whether it is a blanked leading zero.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_ah     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = shadow[4*i +: 4];
        cur_blank = blank_lz && (i != 0) && zero_from[i];
        an_ah[i]  = 1'b1;
      end
    end
    seg_ah = cur_blank ? 7'h00 : decode(cur_digit);
  end

  // Output registers: polarity applied here so the pins switch cleanly on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= ACTIVE_LOW ? ~seg_ah : seg_ah;
      an_q          <= ACTIVE_LOW ? ~an_ah : an_ah;
      frame_start_q <= (idx == '0) && (cnt == '0);
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed loads/blanking/reset against hand-written segment tables.
// Latency: expectations queued one per clock edge, compared on the following falling edge.
// Backpressure: none; monitor consumes one queued expectation per cycle.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst0, load0, blank0;
  logic [15:0] bcd0;
  logic [6:0]  seg0;
  logic [3:0]  an0;
  logic        fs0;

  logic        rst1, load1, blank1;
  logic [15:0] bcd1;
  logic [6:0]  seg1;
  logic [3:0]  an1;
  logic        fs1;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .load(load0), .bcd_in(bcd0), .blank_lz(blank0),
    .seg(seg0), .an(an0), .frame_start(fs0)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .load(load1), .bcd_in(bcd1), .blank_lz(blank1),
    .seg(seg1), .an(an1), .frame_start(fs1)
  );

  typedef struct {
    int         which;
    int         test;
    logic [6:0] seg;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cur_test = 0;
  int   pos0 = 0;   // edge position within a 16-cycle frame of dut0
  int   pos1 = 0;   // edge position within a 4-cycle frame of dut1
  bit   done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int t, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s test%0d @%0t: actual %h required %h", nm, t, $time, got, want);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.which == 0) begin
          chk("seg0", e.test, seg0, e.seg);
          chk("an0",  e.test, {3'b0, an0}, {3'b0, e.an});
          chk("fs0",  e.test, {6'b0, fs0}, {6'b0, e.fs});
        end else begin
          chk("seg1", e.test, seg1, e.seg);
          chk("an1",  e.test, {3'b0, an1}, {3'b0, e.an});
          chk("fs1",  e.test, {6'b0, fs1}, {6'b0, e.fs});
        end
      end
    end
  end

  // One scan edge: s0..s3 are the expected segment codes for digits 0..3.
  task automatic tick(input int which, input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    exp_t       e;
    int         d;
    logic [6:0] sv [4];
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    e.which = which;
    e.test  = cur_test;
    if (which == 0) begin
      d    = pos0 / 4;
      e.fs = (pos0 == 0);
      pos0 = (pos0 + 1) % 16;
      e.an = 4'b0001 << d;
    end else begin
      d    = pos1;
      e.fs = (pos1 == 0);
      pos1 = (pos1 + 1) % 4;
      e.an = ~(4'b0001 << d);
    end
    e.seg = sv[d];
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic rst_tick(input int which);
    exp_t e;
    e.which = which;
    e.test  = cur_test;
    e.seg   = (which == 0) ? 7'h00 : 7'h7F;
    e.an    = (which == 0) ? 4'b0000 : 4'b1111;
    e.fs    = 1'b0;
    if (which == 0) pos0 = 0;
    else pos1 = 0;
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  // Stimulus
  initial begin
    rst0 = 1'b1; load0 = 1'b0; bcd0 = 16'h0000; blank0 = 1'b0;
    rst1 = 1'b1; load1 = 1'b0; bcd1 = 16'h0000; blank1 = 1'b0;

    // 1: reset (load during reset ignored), then 1234 scanning for two frames
    cur_test = 1;
    rst_tick(0);
    load0 = 1'b1; bcd0 = 16'h8888;
    rst_tick(0);
    rst0 = 1'b0; bcd0 = 16'h1234;
    tick(0, 7'h3F, 7'h4F, 7'h5B, 7'h06);          // still the cleared shadow on this edge
    load0 = 1'b0;
    for (int i = 0; i < 31; i++) tick(0, 7'h66, 7'h4F, 7'h5B, 7'h06);

    // 2: load 0007 with leading-zero blanking
    cur_test = 2;
    load0 = 1'b1; bcd0 = 16'h0007; blank0 = 1'b1;
    tick(0, 7'h66, 7'h4F, 7'h5B, 7'h06);
    load0 = 1'b0;
    for (int i = 0; i < 31; i++) tick(0, 7'h07, 7'h00, 7'h00, 7'h00);

    // 3: same digits, blanking off
    cur_test = 3;
    blank0 = 1'b0;
    for (int i = 0; i < 16; i++) tick(0, 7'h07, 7'h3F, 7'h3F, 7'h3F);

    // 4: 0A05 with blanking: dash on digit 2, zero below it kept, digit 3 blank
    cur_test = 4;
    load0 = 1'b1; bcd0 = 16'h0A05; blank0 = 1'b1;
    tick(0, 7'h07, 7'h3F, 7'h3F, 7'h3F);
    load0 = 1'b0;
    for (int i = 0; i < 31; i++) tick(0, 7'h6D, 7'h3F, 7'h40, 7'h00);

    // 5: 5555, then 9999 loaded in the middle of digit 2's slot
    cur_test = 5;
    load0 = 1'b1; bcd0 = 16'h5555;
    tick(0, 7'h6D, 7'h3F, 7'h40, 7'h00);
    load0 = 1'b0;
    for (int i = 0; i < 8; i++) tick(0, 7'h6D, 7'h6D, 7'h6D, 7'h6D);
    load0 = 1'b1; bcd0 = 16'h9999;
    tick(0, 7'h6D, 7'h6D, 7'h6D, 7'h6D);          // load edge: old value still shown
    load0 = 1'b0;
    for (int i = 0; i < 6; i++) tick(0, 7'h6F, 7'h6F, 7'h6F, 7'h6F);

    // 7: one-cycle reset mid-frame; shadow cleared, frame restarts immediately
    cur_test = 7;
    for (int i = 0; i < 5; i++) tick(0, 7'h6F, 7'h6F, 7'h6F, 7'h6F);
    rst0 = 1'b1;
    rst_tick(0);
    rst0 = 1'b0;
    for (int i = 0; i < 17; i++) tick(0, 7'h3F, 7'h00, 7'h00, 7'h00);

    // 6: active-low, one cycle per digit, all zeros
    cur_test = 6;
    rst_tick(1);
    rst_tick(1);
    rst1 = 1'b0; load1 = 1'b1; bcd1 = 16'h0000;
    tick(1, 7'h40, 7'h40, 7'h40, 7'h40);
    load1 = 1'b0;
    for (int i = 0; i < 7; i++) tick(1, 7'h40, 7'h40, 7'h40, 7'h40);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: actual %0d entries left, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised multi-digit seven-segment display driver. It captures a packed vector of BCD digits into a shadow register and time-multiplexes them onto one shared segment bus. Digit-enable (anode) lines scan one digit per refresh slot. It adds leading-zero blanking, invalid-code indication, selectable output polarity and a frame-start pulse, and sits between counter/arithmetic datapaths and the board display pins.

## Interface
- NUM_DIGITS, 4: digits driven; legal 1..8.
- REFRESH_DIV, 100000: clock cycles each digit is held; legal ≥1.
- ACTIVE_LOW, 0: 1 = seg and an are both active-low at the pins; 0 = both active-high.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture bcd_in into the shadow register on this edge.
- bcd_in  in  4*NUM_DIGITS  packed BCD; bits [3:0] = digit 0 (least significant).
- blank_lz  in  1  enable leading-zero blanking.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- an  out  NUM_DIGITS  one-hot digit enable; an[i] drives digit i.
- frame_start  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Shadow register (4*NUM_DIGITS bits) loads bcd_in on any clock edge with load=1 and rst=0. It holds otherwise and resets to all zeros.
- Refresh counter, width max(1, clog2(REFRESH_DIV)), counts 0..REFRESH_DIV-1 and then wraps to 0.
- Digit index, width max(1, clog2(NUM_DIGITS)):
  - Advances by 1 on the edge where the counter is at REFRESH_DIV-1.
  - Wraps from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1 it stays at 0.
- Segment decode, active-high view, for values 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Codes 10–15 display a dash (g only, 40h).
- Leading-zero blanking applies when blank_lz=1:
  - Digit i (i>0) is blanked (segments 00h) when shadow digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - The anode of a blanked digit is still driven.
- Outputs are registered. Each edge loads seg/an from the current index, shadow and blank_lz (the values before the edge).
- an is the one-hot of the index.
- frame_start is registered high when the index is 0 and the counter is 0.
- Polarity: when ACTIVE_LOW=1, the seg and an registers hold the bitwise inverse of the active-high value. frame_start is always active-high.

## Timing
- While rst=1, the following values hold on the edge:
  - seg = all segments off (00h, or 7Fh if ACTIVE_LOW).
  - an = all off.
  - frame_start = 0.
  - Counter, index and shadow = 0.
- On the first edge with rst=0:
  - Outputs show digit 0 of the shadow and frame_start=1.
  - Counter goes to 1, or stays 0 with the index advancing if REFRESH_DIV=1.
- Each digit is displayed for exactly REFRESH_DIV consecutive cycles.
- A full frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- frame_start is high for 1 cycle per frame, coincident with the first cycle digit 0 is shown.
- Load latency: bcd_in sampled at edge N appears on seg at edge N+1, provided the corresponding digit is selected then. A load mid-slot changes the currently displayed digit's segments without moving the scan.
- blank_lz changes take effect with the same 1-cycle latency.
- load during rst=1 is ignored, because reset wins.
- rst asserted mid-frame: outputs go to the off state on that edge. Scanning restarts at digit 0 after release, and the shadow is cleared.
- Exactly one an bit is active at all times outside reset. No cycle has zero or two enables.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0 unless stated.

- **Reset, then load 1234h:** after release, an sequence is 0001, 0010, 0100, 1000, each held 4 cycles. seg sequence is 66h, 4Fh, 5Bh, 06h. frame_start pulses every 16 cycles.
- **Load 0007h, blank_lz=1:** digit 0 shows 07h. Digits 1–3 show 00h with their an bits still cycling.
- **Same load with blank_lz=0:** digits 1–3 show 3Fh.
- **Load 0A05h, blank_lz=1:** digit 2 shows a dash (40h) and digit 1 shows 3Fh, because zeros below a non-zero digit are not blanked. Digit 3 is blanked.
- **Load 5555h, then load 9999h mid-slot while digit 2 is displayed:** seg changes 6Dh→6Fh exactly one cycle after the load edge. Slot length and an are unchanged.
- **ACTIVE_LOW=1, REFRESH_DIV=1, load 0000h:**
  - During reset, seg=7Fh and an=1111.
  - After release, an rotates 1110, 1101, 1011, 0111 every cycle.
  - seg=40h (inverse of 3Fh) for every digit.
- **Assert rst for 1 cycle mid-frame:** outputs go to the off state, the shadow is cleared, and the next frame_start occurs on the first cycle after release.
